sata_oob_ctrl: RTL and testbench

- Host-side SATA out-of-band (OOB) link-initialization sequencer.
- Starts once the PHY reset/init sequencer reports complete.
- Drives the transceiver OOB signalling in order: COMRESET, then COMWAKE, then D10.2, then ALIGN. Handles timeouts and retries, and asserts link-up for the link layer.

---
 rtl/sata_oob_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_sata_oob_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sata_oob_ctrl.sv
// Host-side SATA OOB link-initialization sequencer: COMRESET, COMWAKE, D10.2, ALIGN,
// with per-stage response timeouts, bounded COMRESET retries and device-initiated restart.
module sata_oob_ctrl #(
    parameter logic [16:0] TIMEOUT_CYCLES = 17'd66000,
    parameter logic [3:0]  MAX_RETRIES    = 4'd8,
    parameter logic [3:0]  ALIGN_HOLD     = 4'd8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_phy_ready,
    output logic       o_tx_cominit,
    output logic       o_tx_comwake,
    input  logic       i_tx_oob_done,
    output logic       o_tx_elecidle,
    output logic       o_tx_d102,
    output logic       o_tx_align,
    input  logic       i_cominit_det,
    input  logic       i_comwake_det,
    input  logic       i_rx_elecidle,
    input  logic       i_rx_align,
    output logic       o_link_up,
    output logic       o_err,
    output logic [3:0] o_retries
);

    localparam logic [3:0] ST_IDLE         = 4'd0;
    localparam logic [3:0] ST_COMRESET     = 4'd1;
    localparam logic [3:0] ST_WAIT_COMINIT = 4'd2;
    localparam logic [3:0] ST_COMWAKE      = 4'd3;
    localparam logic [3:0] ST_WAIT_COMWAKE = 4'd4;
    localparam logic [3:0] ST_WAIT_ALIGN   = 4'd5;
    localparam logic [3:0] ST_SEND_ALIGN   = 4'd6;
    localparam logic [3:0] ST_LINK_UP      = 4'd7;
    localparam logic [3:0] ST_FAIL         = 4'd8;

    // Zero-valued parameters load 0 rather than wrapping to the counter maximum.
    localparam logic [16:0] TIMER_LOAD = (TIMEOUT_CYCLES == 17'd0) ? 17'd0 : TIMEOUT_CYCLES - 17'd1;
    localparam logic [3:0]  HOLD_LOAD  = (ALIGN_HOLD == 4'd0) ? 4'd0 : ALIGN_HOLD - 4'd1;

    logic [3:0]  state_q,    state_d;
    logic [16:0] timer_q,    timer_d;
    logic [3:0]  hold_q,     hold_d;
    logic [3:0]  retries_q,  retries_d;
    logic        cominit_q,  cominit_d;
    logic        comwake_q,  comwake_d;
    logic        elecidle_q, elecidle_d;
    logic        d102_q,     d102_d;
    logic        align_q,    align_d;
    logic        link_up_q,  link_up_d;
    logic        err_q,      err_d;

    logic        in_wait;
    logic        timed_out;
    logic        take_timeout;
    logic [3:0]  retries_inc;
    logic        entering_wait;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        hold_d       = hold_q;
        retries_d    = retries_q;
        take_timeout = 1'b0;

        in_wait     = (state_q == ST_WAIT_COMINIT) || (state_q == ST_WAIT_COMWAKE) ||
                      (state_q == ST_WAIT_ALIGN);
        timed_out   = in_wait && (timer_q == 17'd0);
        retries_inc = (retries_q == 4'hF) ? 4'hF : retries_q + 4'd1;

        if (in_wait && (timer_q != 17'd0)) begin
            timer_d = timer_q - 17'd1;
        end

        if (!i_phy_ready) begin
            state_d   = ST_IDLE;
            retries_d = 4'd0;
            timer_d   = 17'd0;
            hold_d    = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_COMRESET;
                end
                ST_COMRESET: begin
                    if (i_tx_oob_done) begin
                        state_d = ST_WAIT_COMINIT;
                    end
                end
                ST_WAIT_COMINIT: begin
                    // A detection arriving on the expiry cycle still counts as a response.
                    if (i_cominit_det) begin
                        state_d = ST_COMWAKE;
                    end else if (timed_out) begin
                        take_timeout = 1'b1;
                    end
                end
                ST_COMWAKE: begin
                    if (i_tx_oob_done) begin
                        state_d = ST_WAIT_COMWAKE;
                    end
                end
                ST_WAIT_COMWAKE: begin
                    if (i_comwake_det) begin
                        state_d = ST_WAIT_ALIGN;
                    end else if (timed_out) begin
                        take_timeout = 1'b1;
                    end
                end
                ST_WAIT_ALIGN: begin
                    if (i_rx_align && !i_rx_elecidle) begin
                        state_d = ST_SEND_ALIGN;
                        hold_d  = HOLD_LOAD;
                    end else if (timed_out) begin
                        take_timeout = 1'b1;
                    end
                end
                ST_SEND_ALIGN: begin
                    if (hold_q == 4'd0) begin
                        state_d   = ST_LINK_UP;
                        retries_d = 4'd0;
                    end else begin
                        hold_d = hold_q - 4'd1;
                    end
                end
                ST_LINK_UP: begin
                    // Device-initiated reset: skip COMRESET and answer with COMWAKE.
                    if (i_cominit_det) begin
                        state_d = ST_COMWAKE;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (take_timeout) begin
                retries_d = retries_inc;
                if ((MAX_RETRIES != 4'd0) && (retries_inc == MAX_RETRIES)) begin
                    state_d = ST_FAIL;
                end else begin
                    state_d = ST_COMRESET;
                end
            end
        end

        entering_wait = (state_d != state_q) &&
                        ((state_d == ST_WAIT_COMINIT) || (state_d == ST_WAIT_COMWAKE) ||
                         (state_d == ST_WAIT_ALIGN));
        if (entering_wait) begin
            timer_d = TIMER_LOAD;
        end

        // Outputs are decoded from the next state so they line up with the registered state.
        cominit_d  = (state_d == ST_COMRESET) && (state_q != ST_COMRESET);
        comwake_d  = (state_d == ST_COMWAKE)  && (state_q != ST_COMWAKE);
        elecidle_d = !((state_d == ST_WAIT_ALIGN) || (state_d == ST_SEND_ALIGN) ||
                       (state_d == ST_LINK_UP));
        d102_d     = (state_d == ST_WAIT_ALIGN);
        align_d    = (state_d == ST_SEND_ALIGN);
        link_up_d  = (state_d == ST_LINK_UP);
        err_d      = (state_d == ST_FAIL);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= 17'd0;
            hold_q     <= 4'd0;
            retries_q  <= 4'd0;
            cominit_q  <= 1'b0;
            comwake_q  <= 1'b0;
            elecidle_q <= 1'b1;
            d102_q     <= 1'b0;
            align_q    <= 1'b0;
            link_up_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            hold_q     <= hold_d;
            retries_q  <= retries_d;
            cominit_q  <= cominit_d;
            comwake_q  <= comwake_d;
            elecidle_q <= elecidle_d;
            d102_q     <= d102_d;
            align_q    <= align_d;
            link_up_q  <= link_up_d;
            err_q      <= err_d;
        end
    end

    assign o_tx_cominit  = cominit_q;
    assign o_tx_comwake  = comwake_q;
    assign o_tx_elecidle = elecidle_q;
    assign o_tx_d102     = d102_q;
    assign o_tx_align    = align_q;
    assign o_link_up     = link_up_q;
    assign o_err         = err_q;
    assign o_retries     = retries_q;

endmodule

// File: tb/tb_sata_oob_ctrl.sv
// Bench for sata_oob_ctrl: a cycle table replayed through a scoreboard queue, then
// hand-written sequences for bring-up, timeouts, retry exhaustion, races and device reset.
module tb_sata_oob_ctrl;

    logic       clk;
    logic       rst;
    logic       phy;
    logic       done;
    logic       ci_det;
    logic       cw_det;
    logic       rx_idle;
    logic       rx_align;
    logic       o_tx_cominit;
    logic       o_tx_comwake;
    logic       o_tx_elecidle;
    logic       o_tx_d102;
    logic       o_tx_align;
    logic       o_link_up;
    logic       o_err;
    logic [3:0] o_retries;

    sata_oob_ctrl #(
        .TIMEOUT_CYCLES(17'd100),
        .MAX_RETRIES   (4'd3),
        .ALIGN_HOLD    (4'd8)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_phy_ready  (phy),
        .o_tx_cominit (o_tx_cominit),
        .o_tx_comwake (o_tx_comwake),
        .i_tx_oob_done(done),
        .o_tx_elecidle(o_tx_elecidle),
        .o_tx_d102    (o_tx_d102),
        .o_tx_align   (o_tx_align),
        .i_cominit_det(ci_det),
        .i_comwake_det(cw_det),
        .i_rx_elecidle(rx_idle),
        .i_rx_align   (rx_align),
        .o_link_up    (o_link_up),
        .o_err        (o_err),
        .o_retries    (o_retries)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        phy;
        logic        done;
        logic        ci;
        logic        cw;
        logic        rxi;
        logic        rxa;
        logic [10:0] exp;
    } vec_t;

    localparam int NVEC = 29;
    vec_t        tbl [NVEC];
    logic [10:0] sb_q [$];

    int   checks  = 0;
    int   errors  = 0;
    int   n_ci    = 0;
    int   n_cw    = 0;
    int   n_al    = 0;
    int   bad_adj = 0;
    logic prev_p  = 1'b0;

    function automatic logic [10:0] ov(logic e, logic ci, logic cw, logic d, logic a,
                                       logic l, logic er, logic [3:0] r);
        return {e, ci, cw, d, a, l, er, r};
    endfunction

    function automatic vec_t mv(logic r, logic p, logic dn, logic ci, logic cw,
                                logic rxi, logic rxa, logic [10:0] e);
        vec_t v;
        v.rst = r; v.phy = p; v.done = dn; v.ci = ci; v.cw = cw;
        v.rxi = rxi; v.rxa = rxa; v.exp = e;
        return v;
    endfunction

    function automatic logic [10:0] outs();
        return {o_tx_elecidle, o_tx_cominit, o_tx_comwake, o_tx_d102, o_tx_align,
                o_link_up, o_err, o_retries};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end else begin
            $display("ok   %s = %0h", name, got);
        end
    endtask

    task automatic tick();
        logic p;
        @(posedge clk);
        #1;
        n_ci += int'(o_tx_cominit);
        n_cw += int'(o_tx_comwake);
        n_al += int'(o_tx_align);
        p = o_tx_cominit | o_tx_comwake;
        if ((o_tx_cominit && o_tx_comwake) || (p && prev_p)) bad_adj++;
        prev_p = p;
    endtask

    task automatic clr_cnt();
        n_ci = 0; n_cw = 0; n_al = 0;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_done();
        done = 1'b1; tick(); done = 1'b0;
    endtask

    task automatic pulse_ci();
        ci_det = 1'b1; tick(); ci_det = 1'b0;
    endtask

    task automatic pulse_cw();
        cw_det = 1'b1; tick(); cw_det = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; phy = 1'b0; done = 1'b0; ci_det = 1'b0; cw_det = 1'b0;
        rx_idle = 1'b1; rx_align = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Counts ticks until o_tx_cominit (sel=0) or o_err (sel=1) rises, bounded.
    task automatic wait_for(input int sel, output int k);
        k = 0;
        do begin
            tick();
            k++;
        end while (!((sel == 0) ? o_tx_cominit : o_err) && k < 150);
    endtask

    // From the first COMWAKE cycle onward: finish the handshake and wait for link-up.
    task automatic link_from_comwake(input string tag);
        int k;
        idle_ticks(10);
        pulse_done();
        idle_ticks(20);
        pulse_cw();
        idle_ticks(3);
        rx_idle = 1'b0; rx_align = 1'b1;
        k = 0;
        while (!o_link_up && k < 40) begin
            tick();
            k++;
        end
        rx_align = 1'b0; rx_idle = 1'b1;
        check({tag, "_link_up"}, 32'(o_link_up), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int           k;
        logic [10:0]  e_idle;
        logic [10:0]  e_cr1;
        logic [10:0]  e_cw1;
        logic [10:0]  e_al;
        logic [10:0]  exp_o;
        e_idle = ov(1, 0, 0, 0, 0, 0, 0, 4'd0);
        e_cr1  = ov(1, 1, 0, 0, 0, 0, 0, 4'd0);
        e_cw1  = ov(1, 0, 1, 0, 0, 0, 0, 4'd0);
        e_al   = ov(0, 0, 0, 0, 1, 0, 0, 4'd0);

        //                rst phy dn ci cw rxi rxa  expected
        tbl[0]  = mv(1, 0, 0, 0, 0, 1, 0, e_idle);
        tbl[1]  = mv(1, 1, 0, 0, 0, 1, 0, e_idle);
        tbl[2]  = mv(0, 0, 0, 0, 0, 1, 0, e_idle);
        tbl[3]  = mv(0, 1, 0, 0, 0, 1, 0, e_cr1);
        tbl[4]  = mv(0, 1, 0, 0, 0, 1, 0, e_idle);
        tbl[5]  = mv(0, 0, 0, 0, 0, 1, 0, e_idle);
        tbl[6]  = mv(0, 0, 1, 0, 0, 1, 0, e_idle);
        tbl[7]  = mv(0, 1, 1, 0, 0, 1, 0, e_cr1);
        tbl[8]  = mv(0, 1, 0, 0, 0, 1, 0, e_idle);
        tbl[9]  = mv(0, 1, 1, 0, 0, 1, 0, e_idle);
        tbl[10] = mv(0, 1, 1, 0, 1, 1, 0, e_idle);
        tbl[11] = mv(0, 1, 0, 1, 0, 1, 0, e_cw1);
        tbl[12] = mv(0, 1, 0, 1, 0, 1, 0, e_idle);
        tbl[13] = mv(0, 1, 1, 0, 0, 1, 0, e_idle);
        tbl[14] = mv(0, 1, 0, 0, 0, 0, 1, e_idle);
        tbl[15] = mv(0, 1, 0, 0, 1, 1, 0, ov(0, 0, 0, 1, 0, 0, 0, 4'd0));
        tbl[16] = mv(0, 1, 0, 0, 0, 1, 1, ov(0, 0, 0, 1, 0, 0, 0, 4'd0));
        for (int i = 17; i <= 24; i++) tbl[i] = mv(0, 1, 0, 0, 0, 0, 1, e_al);
        tbl[25] = mv(0, 1, 0, 0, 0, 0, 0, ov(0, 0, 0, 0, 0, 1, 0, 4'd0));
        tbl[26] = mv(0, 1, 0, 1, 0, 0, 0, e_cw1);
        tbl[27] = mv(0, 1, 0, 0, 0, 0, 0, e_idle);
        tbl[28] = mv(0, 0, 0, 0, 0, 1, 0, e_idle);

        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            rst = tbl[i].rst; phy = tbl[i].phy; done = tbl[i].done; ci_det = tbl[i].ci;
            cw_det = tbl[i].cw; rx_idle = tbl[i].rxi; rx_align = tbl[i].rxa;
            sb_q.push_back(tbl[i].exp);
            tick();
            exp_o = sb_q.pop_front();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(exp_o));
        end
        done = 1'b0; ci_det = 1'b0; cw_det = 1'b0; rx_idle = 1'b1; rx_align = 1'b0;

        // Nominal bring-up with realistic gaps.
        do_reset();
        clr_cnt();
        phy = 1'b1;
        tick();
        idle_ticks(10);
        pulse_done();
        idle_ticks(20);
        pulse_ci();
        link_from_comwake("nominal");
        check("nominal_cominit_pulses", 32'(n_ci), 32'd1);
        check("nominal_comwake_pulses", 32'(n_cw), 32'd1);
        check("nominal_align_cycles", 32'(n_al), 32'd8);
        check("nominal_retries", 32'(o_retries), 32'd0);

        // Device-initiated reset from LINK_UP.
        clr_cnt();
        pulse_ci();
        check("devrst_link_drop", 32'(o_link_up), 32'd0);
        check("devrst_comwake", 32'(o_tx_comwake), 32'd1);
        link_from_comwake("devrst");
        check("devrst_comwake_pulses", 32'(n_cw), 32'd1);
        check("devrst_cominit_pulses", 32'(n_ci), 32'd0);
        check("devrst_align_cycles", 32'(n_al), 32'd8);
        check("devrst_retries", 32'(o_retries), 32'd0);

        // COMINIT timeout, then retries until the limit of 3.
        do_reset();
        phy = 1'b1;
        tick();
        pulse_done();
        wait_for(0, k);
        check("timeout1_delay", 32'(k), 32'd100);
        check("timeout1_retries", 32'(o_retries), 32'd1);
        pulse_done();
        wait_for(0, k);
        check("timeout2_delay", 32'(k), 32'd100);
        check("timeout2_retries", 32'(o_retries), 32'd2);
        pulse_done();
        wait_for(1, k);
        check("fail_delay", 32'(k), 32'd100);
        check("fail_outputs", 32'(outs()), 32'(ov(1, 0, 0, 0, 0, 0, 1, 4'd3)));
        clr_cnt();
        pulse_done();
        pulse_ci();
        idle_ticks(20);
        check("fail_sticky", 32'(outs()), 32'(ov(1, 0, 0, 0, 0, 0, 1, 4'd3)));
        check("fail_no_pulses", 32'(n_ci + n_cw), 32'd0);
        phy = 1'b0;
        tick();
        check("fail_phy_drop", 32'(outs()), 32'(e_idle));
        phy = 1'b1;
        tick();
        check("fail_restart", 32'(outs()), 32'(e_cr1));

        // Detection on the expiry cycle beats the timeout.
        do_reset();
        phy = 1'b1;
        tick();
        pulse_done();
        idle_ticks(99);
        check("race_still_waiting", 32'(outs()), 32'(e_idle));
        pulse_ci();
        check("race_detect_wins", 32'(outs()), 32'(e_cw1));

        check("no_adjacent_pulses", 32'(bad_adj), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
